// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low hex glyphs and segment bit positions.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;
  localparam logic [6:0] SEG_A_HEX = 7'h08;
  localparam logic [6:0] SEG_B_HEX = 7'h60;
  localparam logic [6:0] SEG_C_HEX = 7'h31;
  localparam logic [6:0] SEG_D_HEX = 7'h42;
  localparam logic [6:0] SEG_E_HEX = 7'h30;
  localparam logic [6:0] SEG_F_HEX = 7'h38;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit index of each segment within the 7-bit code, a is the MSB.
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low seven-segment code.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A_HEX;
      4'hB: seg_o = SEG_B_HEX;
      4'hC: seg_o = SEG_C_HEX;
      4'hD: seg_o = SEG_D_HEX;
      4'hE: seg_o = SEG_E_HEX;
      4'hF: seg_o = SEG_F_HEX;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment driver with frame-synchronous shadow registers,
// per-digit dp/blank masks and leading-zero suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp_mask,
  input  logic [DIGITS-1:0]     i_blank_mask,
  input  logic                  i_lz_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic          INV      = ~ACTIVE_LOW;

  logic [CW-1:0]            cnt_q;
  logic [IW-1:0]            idx_q;
  logic [DIGITS-1:0][3:0]   sh_data_q;
  logic [DIGITS-1:0]        sh_dp_q;
  logic [DIGITS-1:0]        sh_blank_q;

  logic                     tick;
  logic                     frame_edge;
  logic [DIGITS-1:0]        upper_zero;
  logic [3:0]               cur_nib;
  logic [6:0]               dec_seg;
  logic                     cur_dark;
  logic [6:0]               seg_d;
  logic                     dp_d;
  logic [DIGITS-1:0]        an_d;

  assign tick       = (cnt_q == CNT_LAST) && i_en;
  assign frame_edge = tick && (idx_q == IDX_LAST);

  // upper_zero[k] is set when shadow nibbles k..DIGITS-1 are all zero.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc           = acc & (sh_data_q[k] == 4'h0);
      upper_zero[k] = acc;
    end
  end

  assign cur_nib  = sh_data_q[idx_q];
  assign cur_dark = sh_blank_q[idx_q] ||
                    (i_lz_en && (idx_q != '0) && upper_zero[idx_q]);

  seg_hex_dec u_dec (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  // Active-low view of the pins; polarity is applied at the output register.
  always_comb begin
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    seg_d       = dec_seg;
    dp_d        = ~sh_dp_q[idx_q];
    if (cur_dark) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
    if (!i_en) begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      o_an       <= {DIGITS{ACTIVE_LOW}};
      o_seg      <= SEG_OFF ^ {7{INV}};
      o_dp       <= ACTIVE_LOW;
      o_frame    <= 1'b0;
    end else begin
      if (i_en) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
      if (tick) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frame_edge) begin
        sh_data_q  <= i_data;
        sh_dp_q    <= i_dp_mask;
        sh_blank_q <= i_blank_mask;
      end
      o_an    <= an_d ^ {DIGITS{INV}};
      o_seg   <= seg_d ^ {7{INV}};
      o_dp    <= dp_d ^ INV;
      o_frame <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan: 4-digit active-low/high instances plus a 1-digit one.
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        lz;

  logic [6:0]  seg0, seg1, seg2;
  logic        dp0, dp1, dp2;
  logic [3:0]  an0, an1;
  logic [0:0]  an2;
  logic        frame0, frame1, frame2;

  int checks;
  int errors;

  seg_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_dp_mask(dp_mask),
    .i_blank_mask(blank_mask), .i_lz_en(lz), .o_seg(seg0), .o_dp(dp0), .o_an(an0),
    .o_frame(frame0)
  );

  seg_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_dp_mask(dp_mask),
    .i_blank_mask(blank_mask), .i_lz_en(lz), .o_seg(seg1), .o_dp(dp1), .o_an(an1),
    .o_frame(frame1)
  );

  seg_scan #(.DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_one (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data[3:0]), .i_dp_mask(dp_mask[0]),
    .i_blank_mask(blank_mask[0]), .i_lz_en(lz), .o_seg(seg2), .o_dp(dp2), .o_an(an2),
    .o_frame(frame2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
      4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
      4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
      4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  // Expected {an, seg, dp, frame} for the active-low 4-digit instance.
  function automatic logic [12:0] exp_out(input int k, input logic [3:0] nib, input logic dpon,
                                          input logic dark, input logic frm);
    logic [3:0] an;
    an    = 4'b1111;
    an[k] = 1'b0;
    return {an, dark ? 7'h7F : hex7(nib), dark ? 1'b1 : ~dpon, frm};
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [12:0] e;
    int k;
    en = 1'b1; data = 16'h1234; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b0;
    rst = 1'b1;
    tick_n(2);
    checks++;
    if ({an0, seg0, dp0, frame0} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_lo got %h want %h", {an0, seg0, dp0, frame0},
               {4'b1111, 7'h7F, 1'b1, 1'b0});
    end
    checks++;
    if ({an1, seg1, dp1, frame1} !== {4'b0000, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hi got %h want %h", {an1, seg1, dp1, frame1},
               {4'b0000, 7'h00, 1'b0, 1'b0});
    end
    checks++;
    if ({an2, seg2, dp2, frame2} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_one got %h want %h", {an2, seg2, dp2, frame2},
               {1'b1, 7'h7F, 1'b1, 1'b0});
    end
    // Run into frame 1 (shadow now holds 1234), then reset at its 7th cycle.
    rst = 1'b0;
    tick_n(23);
    rst = 1'b1;
    tick_n(1);
    checks++;
    if ({an0, seg0, dp0, frame0} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", {an0, seg0, dp0, frame0},
               {4'b1111, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick_n(1);
      k = ((n - 1) / 4) % 4;
      e = exp_out(k, 4'h0, 1'b0, 1'b0, n == 16);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL reset_frame0 n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
    end
  endtask

  task automatic test_scan_order;
    logic [12:0] e;
    logic [3:0] nib;
    int k;
    en = 1'b1; data = 16'h1234; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b0;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      tick_n(1);
      k   = ((n - 1) / 4) % 4;
      nib = (n <= 16) ? 4'h0 : data[4*k +: 4];
      e   = exp_out(k, nib, 1'b0, 1'b0, (n % 16) == 0);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL scan_order n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
      checks++;
      if ({an1, seg1, dp1, frame1} !== {~e[12:1], e[0]}) begin
        errors++;
        $display("FAIL scan_active_high n=%0d got %h want %h", n, {an1, seg1, dp1, frame1},
                 {~e[12:1], e[0]});
      end
    end
  endtask

  task automatic test_tear_free;
    logic [12:0] e;
    logic [15:0] sh;
    int k;
    en = 1'b1; data = 16'h1234; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b0;
    do_reset();
    tick_n(22);
    data = 16'hABCD;
    for (int n = 23; n <= 48; n++) begin
      tick_n(1);
      k  = ((n - 1) / 4) % 4;
      sh = (n <= 32) ? 16'h1234 : 16'hABCD;
      e  = exp_out(k, sh[4*k +: 4], 1'b0, 1'b0, (n % 16) == 0);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL tear_free n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [12:0] e;
    logic [15:0] sh;
    logic [15:0] hi;
    logic supp;
    int k;
    en = 1'b1; data = 16'h0050; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b1;
    do_reset();
    for (int n = 1; n <= 48; n++) begin
      tick_n(1);
      if (n == 20) data = 16'h0000;
      k    = ((n - 1) / 4) % 4;
      sh   = (n >= 17 && n <= 32) ? 16'h0050 : 16'h0000;
      hi   = sh >> (4 * k);
      supp = (k != 0) && (hi == 16'h0);
      e    = exp_out(k, sh[4*k +: 4], 1'b0, supp, (n % 16) == 0);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL leading_zero n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
    end
  endtask

  task automatic test_masks;
    logic [12:0] e;
    logic [15:0] sh;
    logic [3:0] dps;
    logic [3:0] bls;
    int k;
    en = 1'b1; data = 16'h1234; dp_mask = 4'b0010; blank_mask = 4'b1000; lz = 1'b0;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      tick_n(1);
      k   = ((n - 1) / 4) % 4;
      sh  = (n <= 16) ? 16'h0 : 16'h1234;
      dps = (n <= 16) ? 4'b0 : 4'b0010;
      bls = (n <= 16) ? 4'b0 : 4'b1000;
      e   = exp_out(k, sh[4*k +: 4], dps[k], bls[k], (n % 16) == 0);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL masks n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
    end
  endtask

  task automatic test_enable;
    logic [12:0] e;
    int k;
    int m;
    en = 1'b1; data = 16'h1234; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b0;
    do_reset();
    tick_n(18);
    en = 1'b0;
    for (int n = 19; n <= 28; n++) begin
      tick_n(1);
      checks++;
      if ({an0, seg0, dp0, frame0} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL enable_dark n=%0d got %h want %h", n, {an0, seg0, dp0, frame0},
                 {4'b1111, 7'h7F, 1'b1, 1'b0});
      end
    end
    en = 1'b1;
    // Ten disabled cycles shift the schedule by ten.
    for (int n = 29; n <= 46; n++) begin
      tick_n(1);
      m = n - 10;
      k = ((m - 1) / 4) % 4;
      e = exp_out(k, data[4*k +: 4], 1'b0, 1'b0, (m % 16) == 0);
      checks++;
      if ({an0, seg0, dp0, frame0} !== e) begin
        errors++;
        $display("FAIL enable_resume n=%0d got %h want %h", n, {an0, seg0, dp0, frame0}, e);
      end
    end
  endtask

  task automatic test_single_digit;
    logic [9:0] want [6];
    en = 1'b1; data = 16'h0005; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b1;
    want[0] = {1'b0, 7'h01, 1'b1, 1'b1};
    want[1] = {1'b0, 7'h24, 1'b1, 1'b1};
    want[2] = {1'b0, 7'h31, 1'b0, 1'b1};
    want[3] = {1'b1, 7'h7F, 1'b1, 1'b0};
    want[4] = {1'b0, 7'h31, 1'b0, 1'b1};
    want[5] = {1'b0, 7'h7F, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick_n(1);
      checks++;
      if ({an2, seg2, dp2, frame2} !== want[i]) begin
        errors++;
        $display("FAIL single_digit step=%0d got %h want %h", i, {an2, seg2, dp2, frame2},
                 want[i]);
      end
      case (i)
        0: begin data = 16'h000C; dp_mask = 4'b0001; end
        2: en = 1'b0;
        3: begin en = 1'b1; blank_mask = 4'b0001; end
        default: ;
      endcase
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; data = 16'h0; dp_mask = 4'b0; blank_mask = 4'b0; lz = 1'b0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_leading_zero();
    test_masks();
    test_enable();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
